fc_fifo_writer: RTL and testbench
=================================

// Module: fc_fifo_writer
// PURPOSE
//  Write-side partner of the flow-control FSM: accepts words from an upstream source
//  (valid/ready) and pushes them into the FIFO, obeying pausa/continuar/error_full/idle.
//  Sits between the data source and the FIFO write port; the FSM watches FIFO fill level.
//  Provides word/error counters for debug and verification.
// PARAMETERS
//  DATA_W          8   width of data words
//  CNT_W           16  width of word_count (wraps)
//  RECOVER_CYCLES  4   cycles spent in RECOV after error_full drops (>=1)
// PORTS
//  clk         in   1        single clock, all logic on posedge
//  reset       in   1        synchronous, active-high
//  iniciar     in   1        start; sampled only in INIT
//  pausa       in   1        from FSM: stop accepting
//  continuar   in   1        from FSM: resume after pause
//  error_full  in   1        from FSM: FIFO full error
//  idle        in   1        from FSM: FIFO empty, resume allowed
//  in_data     in   DATA_W   upstream word
//  in_valid    in   1        upstream word valid
//  in_ready    out  1        block can accept in_data this cycle
//  push        out  1        FIFO write strobe (registered)
//  data_out    out  DATA_W   FIFO write data (DATA_W+1 with FC_TX_PARITY_EN)
//  tx_state    out  3        current state encoding
//  word_count  out  CNT_W    words pushed, modulo 2^CNT_W
//  err_count   out  8        ERR entries, saturates at 255
// BEHAVIOUR
//  - Reset: tx_state=INIT(000), push=0, data_out=0, word_count=0, err_count=0, in_ready=0.
//  - in_ready = (tx_state==SEND) & ~pausa & ~error_full (combinational, same-cycle gating).
//  - accept = in_valid & in_ready; next edge: push=1, data_out=in_data, word_count+1
//    (2^CNT_W-1 -> 0). No accept: push=0, data_out holds last value. Latency 1 cycle.
//  - States: INIT=000, SEND=001, HOLD=010, ERR=011, RECOV=100. Priority error_full > pausa > continuar/idle.
//  - INIT: iniciar=1 -> SEND; else stay. iniciar ignored in all other states.
//  - SEND: error_full -> ERR; else pausa -> HOLD; else stay.
//  - HOLD: error_full -> ERR; else pausa -> stay (pausa beats continuar);
//    else continuar|idle -> SEND; else stay.
//  - ERR: on every entry err_count+1 (saturating 255). Stay while error_full=1;
//    error_full=0 -> RECOV, recover counter loaded RECOVER_CYCLES-1.
//  - RECOV: in_ready=0; counter decrements; error_full=1 -> ERR (re-entry counts);
//    counter==0 -> SEND. Exactly RECOVER_CYCLES cycles in RECOV when undisturbed.
//  - Word accepted the cycle before pausa/error_full still pushes (registered); no word
//    is ever dropped or duplicated outside reset.
//  - Reset mid-operation: next edge forces reset values; a word accepted in the reset
//    cycle is discarded (no push).
// CONFIGURATION
//  FC_TX_PARITY_EN defined: data_out is DATA_W+1 bits, data_out[DATA_W] = ^in_data
//    (even parity over the word), registered with the data; reset value 0.
//  Not defined: data_out is DATA_W bits, no parity logic.
// TESTING
//  1. reset, iniciar=1 one cycle, in_valid=1 data 0x01..0x05 -> tx_state=001 next cycle;
//     push=1 five cycles, data_out 0x01..0x05 one cycle after each accept; word_count=5.
//  2. pausa=1 3 cycles mid-stream -> in_ready=0 same cycle, tx_state=010; continuar pulse ->
//     SEND; output sequence contiguous, no loss/duplicate.
//  3. error_full=1 & pausa=1 together for 2 cycles -> tx_state=011, err_count=1; then 4
//     cycles tx_state=100 with in_ready=0, then 001.
//  4. CNT_W=4, push 17 words -> word_count=1; 256 error pulses -> err_count stays 255.
//  5. reset=1 mid-stream with in_valid=1 -> next cycle tx_state=000, push=0, counts 0;
//     iniciar=1 while in SEND -> no effect.
//  6. FC_TX_PARITY_EN, in_data=0x07 -> data_out=9'h107; 0x03 -> 9'h003; undefined -> 8-bit port.

Source files
------------

// File: rtl/fc_fifo_writer.sv
// fc_fifo_writer
//   Write-side partner of the flow-control FSM. Accepts words from an upstream
//   valid/ready source and pushes them into the FIFO write port. It obeys the
//   pausa / continuar / error_full / idle controls and keeps debug counters.
//
// Ports
//   clk         in   1         single clock, all logic on posedge
//   reset       in   1         synchronous, active-high
//   iniciar     in   1         start request, only looked at in INIT
//   pausa       in   1         stop accepting
//   continuar   in   1         resume after a pause
//   error_full  in   1         FIFO full error
//   idle        in   1         FIFO empty, resume allowed
//   in_data     in   DATA_W    upstream word
//   in_valid    in   1         upstream word valid
//   in_ready    out  1         word can be taken this cycle (combinational)
//   push        out  1         registered FIFO write strobe
//   data_out    out  DATA_W    registered FIFO write data (DATA_W+1 with parity)
//   tx_state    out  3         INIT=000 SEND=001 HOLD=010 ERR=011 RECOV=100
//   word_count  out  CNT_W     words pushed, wraps
//   err_count   out  8         ERR entries, saturates at 255
//
// Build option
//   FC_TX_PARITY_EN : data_out gains an even-parity bit at position DATA_W.

module fc_fifo_writer #(
  parameter int DATA_W         = 8,
  parameter int CNT_W          = 16,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              pausa,
  input  logic              continuar,
  input  logic              error_full,
  input  logic              idle,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              push,
`ifdef FC_TX_PARITY_EN
  output logic [DATA_W:0]   data_out,
`else
  output logic [DATA_W-1:0] data_out,
`endif
  output logic [2:0]        tx_state,
  output logic [CNT_W-1:0]  word_count,
  output logic [7:0]        err_count
);

`ifdef FC_TX_PARITY_EN
  localparam int OUT_W = DATA_W + 1;
`else
  localparam int OUT_W = DATA_W;
`endif

  // Counter only has to hold RECOVER_CYCLES-1 down to 0.
  localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RW-1:0] REC_INIT = RW'(RECOVER_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INIT  = 3'b000,
    ST_SEND  = 3'b001,
    ST_HOLD  = 3'b010,
    ST_ERR   = 3'b011,
    ST_RECOV = 3'b100
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [OUT_W-1:0] fmt_word(input logic [DATA_W-1:0] d);
`ifdef FC_TX_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  state_e             state_q, state_d;
  logic [RW-1:0]      rec_q, rec_d;
  logic [7:0]         err_q, err_d;
  logic               push_q, push_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  assign in_ready = (state_q == ST_SEND) & ~pausa & ~error_full;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    err_d   = err_q;
    case (state_q)
      ST_INIT:  if (iniciar) state_d = ST_SEND;
      ST_SEND: begin
        if (error_full)  state_d = ST_ERR;
        else if (pausa)  state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // pausa outranks a simultaneous continuar/idle
        if (error_full)                 state_d = ST_ERR;
        else if (pausa)                 state_d = ST_HOLD;
        else if (continuar | idle)      state_d = ST_SEND;
      end
      ST_ERR: begin
        if (!error_full) begin
          state_d = ST_RECOV;
          rec_d   = REC_INIT;
        end
      end
      ST_RECOV: begin
        if (error_full)          state_d = ST_ERR;
        else if (rec_q == '0)    state_d = ST_SEND;
        else                     rec_d   = rec_q - RW'(1);
      end
      default: state_d = ST_INIT;
    endcase
    // Count every fresh entry into ERR, including re-entry from RECOV.
    if (state_d == ST_ERR && state_q != ST_ERR) err_d = sat_inc8(err_q);
  end

  always_comb begin
    push_d = accept;
    data_d = accept ? fmt_word(in_data) : data_q;
    cnt_d  = accept ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Output register stage: a word accepted this cycle appears next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      rec_q   <= '0;
      err_q   <= '0;
      push_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      err_q   <= err_d;
      push_q  <= push_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign push       = push_q;
  assign data_out   = data_q;
  assign tx_state   = state_q;
  assign word_count = cnt_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_fc_fifo_writer.sv
module tb_fc_fifo_writer;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int RECOV  = 4;
`ifdef FC_TX_PARITY_EN
  localparam int OUT_W = DATA_W + 1;
`else
  localparam int OUT_W = DATA_W;
`endif

  logic              clk = 1'b0;
  logic              reset, iniciar, pausa, continuar, error_full, idle, in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, push;
  logic [OUT_W-1:0]  data_out;
  logic [2:0]        tx_state;
  logic [CNT_W-1:0]  word_count;
  logic [7:0]        err_count;

  int passed = 0;
  int total  = 0;

  fc_fifo_writer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .RECOVER_CYCLES(RECOV)) dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .pausa(pausa),
    .continuar(continuar), .error_full(error_full), .idle(idle),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .push(push), .data_out(data_out), .tx_state(tx_state),
    .word_count(word_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference model: state as small integers, recovery as "cycles left".
  int               m_state, m_rec, m_wc, m_ec;
  logic             m_push;
  logic [OUT_W-1:0] m_data;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] got_q[$];

  function automatic logic [OUT_W-1:0] fmt(input logic [DATA_W-1:0] d);
`ifdef FC_TX_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  function automatic bit m_rdy();
    return (m_state == 1) && !pausa && !error_full;
  endfunction

  task automatic tick();
    int ns;
    bit acc;
    acc = in_valid && m_rdy();
    if (reset) begin
      m_state = 0; m_rec = 0; m_wc = 0; m_ec = 0; m_push = 1'b0; m_data = '0;
    end else begin
      m_push = acc;
      if (acc) begin
        m_data = fmt(in_data);
        m_wc   = (m_wc + 1) % (1 << CNT_W);
        exp_q.push_back(fmt(in_data));
      end
      ns = m_state;
      case (m_state)
        0: if (iniciar) ns = 1;
        1: if (error_full) ns = 3; else if (pausa) ns = 2;
        2: if (error_full) ns = 3; else if (!pausa && (continuar || idle)) ns = 1;
        3: if (!error_full) begin ns = 4; m_rec = RECOV; end
        4: if (error_full) ns = 3;
           else begin m_rec = m_rec - 1; if (m_rec == 0) ns = 1; end
        default: ns = 0;
      endcase
      if (ns == 3 && m_state != 3 && m_ec < 255) m_ec = m_ec + 1;
      m_state = ns;
    end
    @(posedge clk); #1;
    if (push === 1'b1) got_q.push_back(data_out);
  endtask

  task automatic clear_inputs();
    reset = 0; iniciar = 0; pausa = 0; continuar = 0; error_full = 0; idle = 0;
    in_valid = 0; in_data = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick(); tick();
    total++; if (tx_state !== 3'b000) $display("FAIL reset_state got %0h exp 0", tx_state); else passed++;
    total++; if (push !== 1'b0) $display("FAIL reset_push got %0b exp 0", push); else passed++;
    total++; if (data_out !== '0) $display("FAIL reset_data got %0h exp 0", data_out); else passed++;
    total++; if (word_count !== '0 || err_count !== 8'd0)
      $display("FAIL reset_counts got wc=%0d ec=%0d exp 0/0", word_count, err_count); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_ready got %0b exp 0", in_ready); else passed++;
    reset = 0;
  endtask

  task automatic test_stream();
    iniciar = 1; in_valid = 1; in_data = 8'h01;
    tick();
    iniciar = 0;
    total++; if (tx_state !== 3'b001) $display("FAIL t1_state got %0h exp 1", tx_state); else passed++;
    for (int i = 1; i <= 5; i++) begin
      in_data = DATA_W'(i);
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL t1_ready%0d got %0b exp 1", i, in_ready); else passed++;
      tick();
      total++; if (push !== 1'b1 || data_out !== fmt(DATA_W'(i)))
        $display("FAIL t1_push%0d got push=%0b data=%0h exp 1/%0h", i, push, data_out, fmt(DATA_W'(i)));
      else passed++;
    end
    in_valid = 0;
    tick();
    total++; if (push !== 1'b0 || data_out !== fmt(8'h05))
      $display("FAIL t1_hold got push=%0b data=%0h exp 0/%0h", push, data_out, fmt(8'h05)); else passed++;
    total++; if (word_count !== 4'd5) $display("FAIL t1_count got %0d exp 5", word_count); else passed++;
  endtask

  task automatic test_pause();
    int start;
    logic [DATA_W-1:0] nxt;
    bit ok;
    start = got_q.size();
    nxt = 8'h40;
    in_valid = 1;
    for (int c = 0; c < 12; c++) begin
      pausa     = (c >= 3 && c <= 5);
      continuar = (c == 6);
      in_data   = nxt;
      #1;
      if (pausa) begin
        total++; if (in_ready !== 1'b0) $display("FAIL t2_ready_pause%0d got %0b exp 0", c, in_ready); else passed++;
      end
      if (in_valid && m_rdy()) nxt = nxt + 1;
      tick();
      if (c >= 3 && c <= 5) begin
        total++; if (tx_state !== 3'b010) $display("FAIL t2_hold%0d got %0h exp 2", c, tx_state); else passed++;
      end
    end
    pausa = 0; continuar = 0; in_valid = 0;
    tick();
    total++; if (tx_state !== 3'b001) $display("FAIL t2_resume got %0h exp 1", tx_state); else passed++;
    ok = (got_q.size() - start) == int'(nxt - 8'h40);
    for (int k = start; ok && k < got_q.size(); k++)
      if (got_q[k] !== fmt(DATA_W'(8'h40 + (k - start)))) ok = 0;
    total++; if (!ok) $display("FAIL t2_contiguous got %0d words exp %0d", got_q.size() - start, nxt - 8'h40);
    else passed++;
  endtask

  task automatic test_error();
    in_valid = 1; in_data = 8'h77;
    error_full = 1; pausa = 1;
    tick();
    total++; if (tx_state !== 3'b011 || err_count !== 8'd1)
      $display("FAIL t3_err1 got st=%0h ec=%0d exp 3/1", tx_state, err_count); else passed++;
    tick();
    total++; if (tx_state !== 3'b011 || err_count !== 8'd1)
      $display("FAIL t3_err2 got st=%0h ec=%0d exp 3/1", tx_state, err_count); else passed++;
    error_full = 0; pausa = 0;
    tick();
    for (int i = 0; i < RECOV; i++) begin
      total++; if (tx_state !== 3'b100 || in_ready !== 1'b0 || push !== 1'b0)
        $display("FAIL t3_recov%0d got st=%0h rdy=%0b push=%0b exp 4/0/0", i, tx_state, in_ready, push);
      else passed++;
      tick();
    end
    total++; if (tx_state !== 3'b001) $display("FAIL t3_back got %0h exp 1", tx_state); else passed++;
    in_valid = 0;
  endtask

  task automatic test_wrap_saturate();
    clear_inputs();
    reset = 1; tick(); reset = 0;
    iniciar = 1; tick(); iniciar = 0;
    in_valid = 1;
    for (int i = 0; i < 17; i++) begin
      in_data = DATA_W'($urandom);
      tick();
    end
    in_valid = 0;
    tick();
    total++; if (word_count !== 4'd1) $display("FAIL t4_wrap got %0d exp 1", word_count); else passed++;
    for (int p = 0; p < 256; p++) begin
      error_full = 1; tick();
      error_full = 0; tick();
      if (p == 253) begin
        total++; if (err_count !== 8'd254) $display("FAIL t4_ec254 got %0d exp 254", err_count); else passed++;
      end
    end
    total++; if (err_count !== 8'd255) $display("FAIL t4_sat got %0d exp 255", err_count); else passed++;
    total++; if (err_count !== 8'(m_ec)) $display("FAIL t4_model_ec got %0d exp %0d", err_count, m_ec); else passed++;
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    reset = 1; tick(); reset = 0;
    iniciar = 1; tick(); iniciar = 0;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin in_data = DATA_W'($urandom); tick(); end
    in_data = 8'h5A; reset = 1;
    tick();
    total++; if (tx_state !== 3'b000 || push !== 1'b0 || word_count !== '0 || err_count !== 8'd0)
      $display("FAIL t5_reset got st=%0h push=%0b wc=%0d ec=%0d exp 0/0/0/0",
               tx_state, push, word_count, err_count); else passed++;
    reset = 0; in_valid = 0; iniciar = 1;
    tick(); tick(); tick();
    total++; if (tx_state !== 3'b001) $display("FAIL t5_iniciar got %0h exp 1", tx_state); else passed++;
    iniciar = 0;
  endtask

  task automatic test_parity();
    logic [OUT_W-1:0] e7, e3;
`ifdef FC_TX_PARITY_EN
    e7 = 9'h107; e3 = 9'h003;
`else
    e7 = 8'h07; e3 = 8'h03;
`endif
    in_valid = 1; in_data = 8'h07;
    tick();
    total++; if (data_out !== e7) $display("FAIL t6_par07 got %0h exp %0h", data_out, e7); else passed++;
    in_data = 8'h03;
    tick();
    total++; if (data_out !== e3) $display("FAIL t6_par03 got %0h exp %0h", data_out, e3); else passed++;
    in_valid = 0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(59) == 0);
      iniciar    = ($urandom_range(2) == 0);
      pausa      = ($urandom_range(4) == 0);
      continuar  = ($urandom_range(3) == 0);
      error_full = ($urandom_range(7) == 0);
      idle       = ($urandom_range(5) == 0);
      in_valid   = ($urandom_range(3) != 0);
      in_data    = DATA_W'($urandom);
      #1;
      total++; if (in_ready !== m_rdy()) $display("FAIL rnd_ready%0d got %0b exp %0b", c, in_ready, m_rdy());
      else passed++;
      tick();
      total++;
      if (tx_state !== 3'(m_state) || push !== m_push || data_out !== m_data ||
          word_count !== CNT_W'(m_wc) || err_count !== 8'(m_ec))
        $display("FAIL rnd_out%0d got st=%0h push=%0b d=%0h wc=%0d ec=%0d exp %0h/%0b/%0h/%0d/%0d",
                 c, tx_state, push, data_out, word_count, err_count,
                 m_state, m_push, m_data, m_wc, m_ec);
      else passed++;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    bit ok;
    ok = (got_q.size() == exp_q.size());
    for (int k = 0; ok && k < got_q.size(); k++)
      if (got_q[k] !== exp_q[k]) ok = 0;
    total++; if (!ok) $display("FAIL sb_sequence got %0d words exp %0d (or content differs)",
                               got_q.size(), exp_q.size());
    else passed++;
  endtask

  initial begin
    m_state = 0; m_rec = 0; m_wc = 0; m_ec = 0; m_push = 0; m_data = '0;
    test_reset();
    test_stream();
    test_pause();
    test_error();
    test_parity();
    test_wrap_saturate();
    test_reset_mid();
    test_random();
    test_scoreboard();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
